// File: rtl/counter_pkg.sv
// Shared constants for the LED counter: clock rate and the encodings of the
// direction and limit-mode control inputs.
package counter_pkg;
    localparam int unsigned CLK_HZ    = 125_000_000;
    localparam logic        DIR_UP    = 1'b1;
    localparam logic        DIR_DOWN  = 1'b0;
    localparam logic        MODE_WRAP = 1'b0;
    localparam logic        MODE_SAT  = 1'b1;
endpackage

// File: rtl/param_updown_counter_tick_gen.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last one as a
// step request. restart forces the count back to 0 regardless of en.
module tick_gen #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic step
);
    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign step = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/param_updown_counter.sv
// Up/down LED counter with prescaled stepping, synchronous clear/load,
// programmable modulus, wrap or saturate limits, and a terminal-count pulse.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter int unsigned PRESCALE = CLK_HZ / 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tick,
    output logic             tc
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic             step;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;
    logic             at_limit;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (clear | load),
        .step    (step)
    );

    // An out-of-range count counts as the up-limit so it recovers on the next step.
    assign at_limit = (up == DIR_UP) ? (q_q >= MAX_Q) : (q_q == '0);

    always_comb begin
        q_d    = q_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            q_d = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (step) begin
            tick_d = 1'b1;
            tc_d   = at_limit;
            if (up == DIR_UP) begin
                if (!at_limit) q_d = q_q + WIDTH'(1);
                else           q_d = (sat_mode == MODE_SAT) ? MAX_Q : '0;
            end else begin
                if (at_limit)        q_d = (sat_mode == MODE_SAT) ? '0 : MAX_Q;
                else if (q_q > MAX_Q) q_d = MAX_Q;
                else                 q_d = q_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            q_q    <= q_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
        end
    end

    assign Q    = q_q;
    assign tick = tick_q;
    assign tc   = tc_q;
endmodule
